// File: rtl/id_inst_queue.sv
// IF->ID instruction queue: pairs each fetch PC with its synchronous SRAM word in a DEPTH-entry FIFO.
// Optional macro ID_IQ_BYPASS_EN forwards a fetch straight to decode when the queue is empty.
module id_inst_queue #(
  parameter int  DEPTH  = 4,
  parameter int  PC_W   = 32,
  parameter int  INST_W = 32,
  localparam int PTR_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              if_valid,
  input  logic [PC_W-1:0]   if_pc,
  input  logic [INST_W-1:0] inst_sram_rdata,
  output logic              if_stallreq,
  input  logic              id_ready,
  output logic              id_valid,
  output logic [PC_W-1:0]   id_pc,
  output logic [INST_W-1:0] id_inst,
  output logic [PTR_W:0]    count,
  output logic              overflow
);

  logic [PC_W-1:0]   mem_pc   [DEPTH];
  logic [INST_W-1:0] mem_inst [DEPTH];
  logic [PTR_W-1:0]  rd_ptr, wr_ptr;
  logic              full, head_valid;
  logic              pop, push, wr_en, rd_en;

  assign full        = (count == (PTR_W+1)'(DEPTH));
  assign head_valid  = (count != '0);
  // One slot of margin: a fetch issued while stalling still lands a cycle later.
  assign if_stallreq = (count >= (PTR_W+1)'(DEPTH-1));

  always_comb begin
    id_valid = head_valid;
    id_pc    = head_valid ? mem_pc[rd_ptr]   : '0;
    id_inst  = head_valid ? mem_inst[rd_ptr] : '0;
`ifdef ID_IQ_BYPASS_EN
    if (!head_valid && if_valid && !flush) begin
      id_valid = 1'b1;
      id_pc    = if_pc;
      id_inst  = inst_sram_rdata;
    end
`endif
  end

  assign pop  = id_valid & id_ready & ~flush;
  assign push = if_valid & ~flush & (~full | pop);

`ifdef ID_IQ_BYPASS_EN
  // A bypassed word taken by decode the same cycle never touches storage.
  logic bypass_take;
  assign bypass_take = ~head_valid & if_valid & ~flush & id_ready;
  assign wr_en = push & ~bypass_take;
  assign rd_en = pop  & ~bypass_take;
`else
  assign wr_en = push;
  assign rd_en = pop;
`endif

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_pc[wr_ptr]   <= if_pc;
      mem_inst[wr_ptr] <= inst_sram_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (if_valid && !flush && full && !pop)
        overflow <= 1'b1;
      if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
        if (rd_en) rd_ptr <= rd_ptr + PTR_W'(1);
        case ({wr_en, rd_en})
          2'b10:   count <= count + (PTR_W+1)'(1);
          2'b01:   count <= count - (PTR_W+1)'(1);
          default: count <= count;
        endcase
      end
    end
  end

endmodule
